// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory port as seen by the memory-mapped UART transmitter.
// Load/store strobes and data come from the core; read data and window hit go back.
interface uart_tx_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic [3:0]  bus_write;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_read, bus_write, bus_wdata,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_wdata,
    output bus_rdata, bus_hit
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO and bit serializer.
// Status reads are combinational so single-cycle loads complete in the same cycle.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              LVL_W     = PTR_W + 1;
  localparam logic [15:0]     BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       shift_r, shift_s;
  logic [15:0]      cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic             tx_r, tx_s;
  logic             pop_s;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             ovf_r;
  logic             enable_r, irq_en_r;

  logic             hit_s, wr_ok_s, full_s, empty_s, busy_s;
  logic             push_req_s, push_s, ovf_set_s, ovf_clr_s, ctrl_wr_s;
  logic [1:0]       sel_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign hit_s      = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s      = bus.bus_addr[3:2];
  assign wr_ok_s    = hit_s & bus.bus_write[0] & (bus.bus_addr[1:0] == 2'b00);
  assign full_s     = (level_r == DEPTH_LVL);
  assign empty_s    = (level_r == {LVL_W{1'b0}});
  assign busy_s     = (state_r != S_IDLE);

  // Fullness is judged at the start of the cycle, so a same-cycle pop never rescues a push.
  assign push_req_s = wr_ok_s & (sel_s == 2'd0);
  assign push_s     = push_req_s & ~full_s;
  assign ovf_set_s  = push_req_s & full_s;
  assign ovf_clr_s  = wr_ok_s & (sel_s == 2'd1) & bus.bus_wdata[3];
  assign ctrl_wr_s  = wr_ok_s & (sel_s == 2'd2);

  assign unused_s   = ^{bus.bus_write[3:1], bus.bus_wdata[31:8]};

  // Combinational register read mux, zero outside a qualified load.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (hit_s & bus.bus_read) begin
      case (sel_s)
        2'd1:    rdata_s = {20'h0_0000, 4'(level_r), 4'h0, ovf_r, busy_s, empty_s, full_s};
        2'd2:    rdata_s = {30'h0000_0000, irq_en_r, enable_r};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.bus_rdata = rdata_s;
  assign bus.bus_hit   = hit_s;

  // FIFO storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.bus_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Control register.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r <= 1'b0;
      irq_en_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      enable_r <= bus.bus_wdata[0];
      irq_en_r <= bus.bus_wdata[1];
    end
  end

  // Serializer state and registered line driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      shift_r   <= 8'h00;
      cnt_r     <= 16'h0000;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      tx_r      <= tx_s;
    end
  end

  // Next-state logic; tx is derived from the next state so the line changes with the state.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    pop_s     = 1'b0;
    tx_s      = 1'b1;
    case (state_r)
      S_IDLE: begin
        if (enable_r & ~empty_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          cnt_s   = BIT_LAST;
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == 16'h0000) begin
          cnt_s     = BIT_LAST;
          bit_idx_s = 3'd0;
          state_s   = S_DATA;
        end else begin
          cnt_s = cnt_r - 16'h0001;
        end
      end
      S_DATA: begin
        if (cnt_r == 16'h0000) begin
          cnt_s   = BIT_LAST;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = S_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - 16'h0001;
        end
      end
      S_STOP: begin
        if (cnt_r == 16'h0000) begin
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r - 16'h0001;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    case (state_s)
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  assign tx  = tx_r;
  assign irq = irq_en_r & empty_s & ~busy_s;

endmodule
